// File: rtl/jt49_noise_pkg.sv
// Shared constants for the time-multiplexed noise scheduler.
// Contents: LFSR width and taps, FSM state encoding, reset constants.
// Also holds the single-step LFSR function used by the channel datapath.
package jt49_noise_pkg;

  localparam int LFSR_W = 17;
  localparam int TAP_A  = 0;
  localparam int TAP_B  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam state_t              STATE_RST = IDLE;
  localparam logic [LFSR_W-1:0]   LFSR_RST  = '0;

  // The all-zero term re-seeds a cleared register, so reset to zero is legal.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic fb;
    fb = s[TAP_A] ^ s[TAP_B] ^ (s == '0);
    return {fb, s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/jt49_noise_step.sv
// Purpose: next-state of one noise channel (divider counter, /2 toggle, LFSR).
// Latency: purely combinational; the caller registers the result.
// Backpressure: none. Ports: per/cnt/div/lfsr in, cnt_nx/div_nx/lfsr_nx out.
module jt49_noise_step
  import jt49_noise_pkg::*;
#(
  parameter int PW = 5
) (
  input  logic [PW-1:0]     per,
  input  logic [PW-1:0]     cnt,
  input  logic              div,
  input  logic [LFSR_W-1:0] lfsr,
  output logic [PW-1:0]     cnt_nx,
  output logic              div_nx,
  output logic [LFSR_W-1:0] lfsr_nx
);

  logic [PW-1:0] eff;
  logic [PW:0]   cnt_inc;

  always_comb begin
    eff     = (per == '0) ? PW'(1) : per;
    // One extra bit so cnt = all-ones never wraps past the compare.
    cnt_inc = {1'b0, cnt} + (PW+1)'(1);
    cnt_nx  = cnt_inc[PW-1:0];
    div_nx  = div;
    lfsr_nx = lfsr;
    if (cnt_inc >= {1'b0, eff}) begin
      cnt_nx = '0;
      div_nx = ~div;
      // Step on the 0->1 edge of the divider: net rate is one step per 2*eff ticks.
      if (!div) begin
        lfsr_nx = lfsr_step(lfsr);
      end
    end
  end

endmodule

// File: rtl/jt49_noise_sched.sv
// Purpose: NCH noise generators sharing one step datapath, swept round-robin per cen.
// Latency: channel k updates NCH-relative at edge k+1 after cen; noise is registered.
// Backpressure: cen during a sweep is held one-deep when JT49_NOISE_PENDING_EN is
//   defined (a further cen sets sticky overrun); otherwise it is ignored.
// Ports: clk, rst (sync, active-high), cen, per_we/per_sel/per_din, noise[NCH], busy, overrun.
module jt49_noise_sched
  import jt49_noise_pkg::*;
#(
  parameter int NCH = 3,
  parameter int PW  = 5,
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cen,
  input  logic           per_we,
  input  logic [SW-1:0]  per_sel,
  input  logic [PW-1:0]  per_din,
  output logic [NCH-1:0] noise,
  output logic           busy,
  output logic           overrun
);

  localparam logic [SW-1:0] LAST = SW'(NCH - 1);

  logic [PW-1:0]     per_q  [NCH];
  logic [PW-1:0]     cnt_q  [NCH];
  logic              div_q  [NCH];
  logic [LFSR_W-1:0] lfsr_q [NCH];

  state_t        state_q, state_nx;
  logic [SW-1:0] idx_q, idx_nx;
  logic          visit;
  logic          sel_ok;

  logic [PW-1:0]     cnt_nx;
  logic              div_nx;
  logic [LFSR_W-1:0] lfsr_nx;

  jt49_noise_step #(.PW(PW)) u_step (
    .per     (per_q[idx_q]),
    .cnt     (cnt_q[idx_q]),
    .div     (div_q[idx_q]),
    .lfsr    (lfsr_q[idx_q]),
    .cnt_nx  (cnt_nx),
    .div_nx  (div_nx),
    .lfsr_nx (lfsr_nx)
  );

  assign sel_ok = (32'(per_sel) < NCH);

`ifdef JT49_NOISE_PENDING_EN
  logic pend_q, pend_nx;
  logic ovr_q, ovr_nx;
`endif

  always_comb begin
    state_nx = state_q;
    idx_nx   = idx_q;
    visit    = 1'b0;
`ifdef JT49_NOISE_PENDING_EN
    pend_nx  = pend_q;
    ovr_nx   = ovr_q;
`endif
    case (state_q)
      IDLE: begin
        if (cen) begin
          state_nx = SCAN;
          idx_nx   = '0;
        end
      end
      SCAN: begin
        visit  = 1'b1;
        idx_nx = idx_q + SW'(1);
`ifdef JT49_NOISE_PENDING_EN
        if (cen) begin
          if (pend_q) ovr_nx = 1'b1;
          pend_nx = 1'b1;
        end
`endif
        if (idx_q == LAST) begin
          idx_nx   = '0;
          state_nx = IDLE;
`ifdef JT49_NOISE_PENDING_EN
          // A cen on the final visit edge restarts just like a held one.
          if (pend_q || cen) begin
            state_nx = SCAN;
            pend_nx  = 1'b0;
          end
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STATE_RST;
      idx_q   <= '0;
`ifdef JT49_NOISE_PENDING_EN
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
`endif
      for (int i = 0; i < NCH; i++) begin
        per_q[i]  <= '0;
        cnt_q[i]  <= '0;
        div_q[i]  <= 1'b0;
        lfsr_q[i] <= LFSR_RST;
      end
    end else begin
      state_q <= state_nx;
      idx_q   <= idx_nx;
`ifdef JT49_NOISE_PENDING_EN
      pend_q  <= pend_nx;
      ovr_q   <= ovr_nx;
`endif
      if (visit) begin
        cnt_q[idx_q]  <= cnt_nx;
        div_q[idx_q]  <= div_nx;
        lfsr_q[idx_q] <= lfsr_nx;
      end
      // The visit above already read the old period, so a colliding write is safe.
      if (per_we && sel_ok) begin
        per_q[per_sel] <= per_din;
      end
    end
  end

  always_comb begin
    noise = '0;
    for (int i = 0; i < NCH; i++) begin
      noise[i] = lfsr_q[i][LFSR_W-1];
    end
  end

  assign busy = (state_q == SCAN);

`ifdef JT49_NOISE_PENDING_EN
  assign overrun = ovr_q;
`else
  assign overrun = 1'b0;
`endif

endmodule
